seg_scan_mux: RTL and testbench

Parametrised, registered N-channel × W-bit multiplexer for time-multiplexed seven-segment displays. It is the sequential successor of the combinational 2:1 7-bit segment mux. It either follows an externally driven channel select (manual mode) or scans all channels autonomously at a programmable refresh rate (scan mode). Each channel has a blank mask, outputs one-hot digit enables with a ghost-suppression guard interval, and sits between the digit-decode logic and the board's segment/anode pins.

---
 rtl/seg_scan_mux.sv | 102 ++++++++++
 tb/tb_seg_scan_mux.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Registered N-channel x W-bit display multiplexer with manual select or autonomous
// scanning, per-channel blanking and an all-anodes-off guard after every channel change.
module seg_scan_mux #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned W             = 7,
    parameter int unsigned DIV           = 50000,
    parameter int unsigned GUARD         = 2,
    parameter logic [W-1:0] BLANK        = {W{1'b1}},
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    localparam int unsigned SW           = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    input  logic [N_CH*W-1:0]   ent,
    input  logic [N_CH-1:0]     blank_mask,
    output logic [W-1:0]        out,
    output logic [N_CH-1:0]     an,
    output logic [SW-1:0]       idx,
    output logic                tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [N_CH-1:0] AN_OFF = {N_CH{AN_ACTIVE_LOW}};

    logic [CW-1:0]   cnt, cnt_nxt;
    logic [GW-1:0]   gcnt, gcnt_nxt;
    logic [SW-1:0]   idx_nxt;
    logic            prev_mode;
    logic            tick_nxt;
    logic [W-1:0]    out_nxt;
    logic [N_CH-1:0] an_nxt;
    logic [N_CH-1:0] onehot;
    logic [W-1:0]    ch_val;
    logic            ch_blank;
    logic            oor;
    logic            blank;

    // Output path: select current channel, apply blanking and guard interval
    always_comb begin
        ch_val   = BLANK;
        ch_blank = 1'b1;
        onehot   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SW'(k)) begin
                ch_val    = ent[k*W +: W];
                ch_blank  = blank_mask[k];
                onehot[k] = 1'b1;
            end
        end
        oor     = !mode && (32'(sel) >= N_CH);
        blank   = ch_blank | oor;
        out_nxt = blank ? BLANK : ch_val;
        an_nxt  = (blank || (gcnt != '0)) ? AN_OFF : (onehot ^ AN_OFF);
    end

    // Sequencing: scan divider, manual follow, guard countdown
    always_comb begin
        cnt_nxt  = '0;
        idx_nxt  = idx;
        tick_nxt = 1'b0;
        gcnt_nxt = (gcnt != '0) ? gcnt - GW'(1) : gcnt;
        if (mode) begin
            if (!prev_mode) begin
                cnt_nxt = '0;
            end else if (cnt == CW'(DIV - 1)) begin
                cnt_nxt  = '0;
                idx_nxt  = (idx == SW'(N_CH - 1)) ? '0 : idx + SW'(1);
                tick_nxt = 1'b1;
                gcnt_nxt = GW'(GUARD);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end else if (!oor && (sel != idx)) begin
            idx_nxt  = sel;
            gcnt_nxt = GW'(GUARD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            gcnt      <= '0;
            prev_mode <= 1'b0;
            tick      <= 1'b0;
            out       <= BLANK;
            an        <= AN_OFF;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            gcnt      <= gcnt_nxt;
            prev_mode <= mode;
            tick      <= tick_nxt;
            out       <= out_nxt;
            an        <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-channel and a 3-channel instance (DIV=4, GUARD=1)
// checked against a cycle-age/scan-count reference model plus directed scenario checks.
module tb_seg_scan_mux;

    localparam int DIV   = 4;
    localparam int GUARD = 1;

    logic        clk, rst_n, mode;
    logic [1:0]  sel4, sel3;
    logic [27:0] ent4;
    logic [20:0] ent3;
    logic [3:0]  bm4;
    logic [2:0]  bm3;
    logic [6:0]  out4, out3;
    logic [3:0]  an4;
    logic [2:0]  an3;
    logic [1:0]  idx4, idx3;
    logic        tick4, tick3;

    int n_chk = 0;
    int n_pass = 0;

    seg_scan_mux #(.N_CH(4), .W(7), .DIV(DIV), .GUARD(GUARD), .BLANK(7'h7F), .AN_ACTIVE_LOW(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel4), .ent(ent4), .blank_mask(bm4),
        .out(out4), .an(an4), .idx(idx4), .tick(tick4));

    seg_scan_mux #(.N_CH(3), .W(7), .DIV(DIV), .GUARD(GUARD), .BLANK(7'h7F), .AN_ACTIVE_LOW(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel3), .ent(ent3), .blank_mask(bm3),
        .out(out3), .an(an3), .idx(idx3), .tick(tick3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: age = edges since last channel change, scan = edges since scan entry
    int         m_idx[2];
    int         m_age[2];
    int         m_scan[2];
    bit         m_pm[2];
    logic [6:0] e_out[2];
    logic [3:0] e_an[2];
    int         e_idx[2];
    bit         e_tick[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d]  = 0;
            m_age[d]  = GUARD;
            m_scan[d] = 0;
            m_pm[d]   = 1'b0;
            e_out[d]  = 7'h7F;
            e_an[d]   = (d == 0) ? 4'hF : 4'h7;
            e_idx[d]  = 0;
            e_tick[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input int d, input bit md, input int s, input logic [27:0] e, input logic [3:0] bm);
        int n;
        int all_off;
        bit oor;
        bit blk;
        n       = (d == 0) ? 4 : 3;
        all_off = (1 << n) - 1;
        oor     = !md && (s >= n);
        blk     = bm[2'(m_idx[d])] | oor;
        e_out[d]  = blk ? 7'h7F : 7'(e >> (7 * m_idx[d]));
        e_an[d]   = (blk || (m_age[d] < GUARD)) ? 4'(all_off) : 4'(all_off & ~(1 << m_idx[d]));
        e_tick[d] = 1'b0;
        if (md) begin
            if (!m_pm[d]) m_scan[d] = 0;
            else          m_scan[d]++;
            if (m_pm[d] && (m_scan[d] % DIV == 0)) begin
                m_idx[d]  = (m_idx[d] + 1) % n;
                m_age[d]  = 0;
                e_tick[d] = 1'b1;
            end else if (m_age[d] < 1000) begin
                m_age[d]++;
            end
        end else if (!oor && (s != m_idx[d])) begin
            m_idx[d] = s;
            m_age[d] = 0;
        end else if (m_age[d] < 1000) begin
            m_age[d]++;
        end
        m_pm[d]  = md;
        e_idx[d] = m_idx[d];
    endtask

    task automatic advance();
        model_edge(0, mode, int'(sel4), ent4, bm4);
        model_edge(1, mode, int'(sel3), {7'b0, ent3}, {1'b0, bm3});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel4 = '0; sel3 = '0; ent4 = '0; ent3 = '0; bm4 = '0; bm3 = '0;
        model_reset();
        @(posedge clk); #1;
        n_chk++;
        if ({out4, an4, idx4, tick4} !== {7'h7F, 4'hF, 2'd0, 1'b0})
            $display("FAIL reset_init: got %h want %h", {out4, an4, idx4, tick4}, {7'h7F, 4'hF, 2'd0, 1'b0});
        else n_pass++;
        mode = 1'b1; ent4 = 28'($urandom); ent3 = 21'($urandom); rst_n = 1'b1;
        advance();
        n_chk++;
        if ({out4, an4} !== {ent4[6:0], 4'hE}) $display("FAIL reset_release: got %h want %h", {out4, an4}, {ent4[6:0], 4'hE});
        else n_pass++;
        repeat (6) advance();
        n_chk++;
        if (idx4 !== 2'd1) $display("FAIL reset_midscan_idx: got %0d want 1", idx4);
        else n_pass++;
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({out4, an4, idx4, tick4, an3} !== {7'h7F, 4'hF, 2'd0, 1'b0, 3'h7})
            $display("FAIL reset_async: got %h want %h", {out4, an4, idx4, tick4, an3}, {7'h7F, 4'hF, 2'd0, 1'b0, 3'h7});
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        advance();
        n_chk++;
        if (an4 !== 4'hE) $display("FAIL reset_rerelease_an: got %h want e", an4);
        else n_pass++;
    endtask

    task automatic test_scan_wrap();
        logic [13:0] got, exp;
        logic [12:0] got3, exp3;
        int last;
        last = -1;
        mode = 1'b1; bm4 = '0; bm3 = '0;
        ent4 = {7'h03, 7'h02, 7'h01, 7'h00};
        for (int i = 0; i < 24; i++) begin
            advance();
            got = {out4, an4, idx4, tick4};
            exp = {e_out[0], e_an[0], 2'(e_idx[0]), e_tick[0]};
            n_chk++;
            if (got !== exp) $display("FAIL scan_model4 cyc %0d: got %h want %h", i, got, exp);
            else n_pass++;
            got3 = {out3, an3, idx3, tick3};
            exp3 = {e_out[1], e_an[1][2:0], 2'(e_idx[1]), e_tick[1]};
            n_chk++;
            if (got3 !== exp3) $display("FAIL scan_model3 cyc %0d: got %h want %h", i, got3, exp3);
            else n_pass++;
            if (tick4) begin
                if (last >= 0) begin
                    n_chk++;
                    if (i - last != DIV) $display("FAIL scan_tick_gap: got %0d want %0d", i - last, DIV);
                    else n_pass++;
                end
                last = i;
            end
        end
    endtask

    task automatic test_blank();
        logic [13:0] got, exp;
        logic [1:0]  prev;
        mode = 1'b1; bm4 = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            prev = idx4;
            advance();
            got = {out4, an4, idx4, tick4};
            exp = {e_out[0], e_an[0], 2'(e_idx[0]), e_tick[0]};
            n_chk++;
            if (got !== exp) $display("FAIL blank_model4 cyc %0d: got %h want %h", i, got, exp);
            else n_pass++;
            if (prev == 2'd2) begin
                n_chk++;
                if ({out4, an4} !== {7'h7F, 4'hF}) $display("FAIL blank_ch2: got %h want %h", {out4, an4}, {7'h7F, 4'hF});
                else n_pass++;
            end
        end
        bm4 = '0;
    endtask

    task automatic test_manual();
        mode = 1'b0; sel4 = 2'd0; sel3 = 2'd0;
        ent4 = {7'h03, 7'h02, 7'h01, 7'h00};
        repeat (3) advance();
        sel4 = 2'd3;
        advance();
        n_chk++;
        if (idx4 !== 2'd3) $display("FAIL manual_idx: got %0d want 3", idx4);
        else n_pass++;
        advance();
        n_chk++;
        if ({out4, an4} !== {7'h03, 4'hF}) $display("FAIL manual_guard: got %h want %h", {out4, an4}, {7'h03, 4'hF});
        else n_pass++;
        advance();
        n_chk++;
        if (an4 !== 4'h7) $display("FAIL manual_an: got %h want 7", an4);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            advance();
            n_chk++;
            if ({tick4, idx4, an4, out4} !== {1'b0, 2'd3, 4'h7, 7'h03})
                $display("FAIL manual_hold: got %h want %h", {tick4, idx4, an4, out4}, {1'b0, 2'd3, 4'h7, 7'h03});
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; sel3 = 2'd0; bm3 = '0;
        ent3 = {7'h22, 7'h11, 7'h05};
        repeat (3) advance();
        sel3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_chk++;
            if ({out3, an3, idx3} !== {7'h7F, 3'h7, 2'd0})
                $display("FAIL oor_blank: got %h want %h", {out3, an3, idx3}, {7'h7F, 3'h7, 2'd0});
            else n_pass++;
        end
        sel3 = 2'd1;
        advance();
        n_chk++;
        if ({idx3, out3, an3} !== {2'd1, 7'h05, 3'b110})
            $display("FAIL oor_recover: got %h want %h", {idx3, out3, an3}, {2'd1, 7'h05, 3'b110});
        else n_pass++;
        advance();
        n_chk++;
        if ({out3, an3} !== {7'h11, 3'h7}) $display("FAIL oor_guard: got %h want %h", {out3, an3}, {7'h11, 3'h7});
        else n_pass++;
        advance();
        n_chk++;
        if (an3 !== 3'b101) $display("FAIL oor_an: got %h want 5", an3);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        int k;
        mode = 1'b0; sel4 = 2'd1;
        repeat (3) advance();
        mode = 1'b1;
        repeat (3) advance();
        mode = 1'b0;
        repeat (3) advance();
        n_chk++;
        if ({idx4, tick4} !== {2'd1, 1'b0}) $display("FAIL mode_manual_idx: got %h want %h", {idx4, tick4}, {2'd1, 1'b0});
        else n_pass++;
        mode = 1'b1;
        k = 0;
        while (k < 10) begin
            advance();
            k++;
            if (tick4) break;
            n_chk++;
            if (idx4 !== 2'd1) $display("FAIL mode_hold_idx: got %0d want 1", idx4);
            else n_pass++;
        end
        n_chk++;
        if (k - 1 != DIV) $display("FAIL mode_tick_gap: got %0d want %0d", k - 1, DIV);
        else n_pass++;
        n_chk++;
        if (idx4 !== 2'd2) $display("FAIL mode_next_idx: got %0d want 2", idx4);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        logic [12:0] got3, exp3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) begin
                sel4 = 2'($urandom);
                sel3 = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) begin
                ent4 = 28'($urandom);
                ent3 = 21'($urandom);
            end
            if ($urandom_range(0, 19) == 0) begin
                bm4 = 4'($urandom) & 4'($urandom);
                bm3 = 3'($urandom) & 3'($urandom);
            end
            advance();
            got = {out4, an4, idx4, tick4};
            exp = {e_out[0], e_an[0], 2'(e_idx[0]), e_tick[0]};
            n_chk++;
            if (got !== exp) $display("FAIL rand_model4 cyc %0d: got %h want %h", i, got, exp);
            else n_pass++;
            got3 = {out3, an3, idx3, tick3};
            exp3 = {e_out[1], e_an[1][2:0], 2'(e_idx[1]), e_tick[1]};
            n_chk++;
            if (got3 !== exp3) $display("FAIL rand_model3 cyc %0d: got %h want %h", i, got3, exp3);
            else n_pass++;
            n_chk++;
            if ($countones(~an4) > 1) $display("FAIL rand_an_exclusive: got %h want at most one low bit", an4);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_wrap();
        test_blank();
        test_manual();
        test_out_of_range();
        test_mode_switch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
